// File: rtl/score_max_tracker.sv
// Tracks the signed maximum score and its (row, col) position over a raster-order
// ROWS x COLS cell stream, then offers the result through a valid/ready handshake.
module score_max_tracker #(
  parameter int W    = 12,
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_score,
  output logic          in_ready,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  best_score,
  output logic [RW-1:0] best_row,
  output logic [CW-1:0] best_col
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state, state_next;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          first;
  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          take;

  assign in_ready = (state == SCAN);
  assign accept   = in_valid && in_ready;
  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));
  // Strict compare keeps the earliest raster position on ties.
  assign take     = accept && (first || ($signed(in_score) > $signed(best_score)));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (accept && last_col && last_row) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      best_score <= '0;
      best_row   <= '0;
      best_col   <= '0;
      row        <= '0;
      col        <= '0;
      first      <= 1'b1;
    end else begin
      state     <= state_next;
      // Status flags come from the next state so they line up with the state register.
      busy      <= (state_next != IDLE);
      out_valid <= (state_next == DONE);

      if (state == IDLE && start) begin
        row   <= '0;
        col   <= '0;
        first <= 1'b1;
      end

      if (take) begin
        best_score <= in_score;
        best_row   <= row;
        best_col   <= col;
        first      <= 1'b0;
      end

      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_max_tracker.sv
// Scoreboard bench for score_max_tracker at ROWS=4, COLS=4, W=12.
module tb_score_max_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_score = '0;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] best_score;
  logic [1:0]  best_row;
  logic [1:0]  best_col;

  typedef struct packed {
    logic [11:0] s;
    logic [1:0]  r;
    logic [1:0]  c;
  } res_t;

  res_t exp_q[$];
  int   stim[16];
  int   checks = 0;
  int   errors = 0;

  score_max_tracker #(.W(12), .ROWS(4), .COLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_score(in_score), .in_ready(in_ready), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .best_score(best_score),
    .best_row(best_row), .best_col(best_col)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one full scan of stim[]; optional idle cycle before each beat and an
  // optional start pulse alongside beat start_beat. Pushes the expected result.
  task automatic drive_scan(input bit bubbles, input int start_beat);
    int best = stim[0];
    int bi = 0;
    for (int i = 1; i < 16; i++) if (stim[i] > best) begin best = stim[i]; bi = i; end
    exp_q.push_back('{s: 12'(best), r: 2'(bi / 4), c: 2'(bi % 4)});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        in_score = 12'h7FF;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_score = 12'(stim[i]);
      start = (i == start_beat);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_out(output bit got, output res_t obs);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin got = 1'b1; break; end
    end
    obs = '{s: best_score, r: best_row, c: best_col};
  endtask

  task automatic handshake(input bit with_start);
    @(posedge clk); #1 out_ready = 1'b1; start = with_start;
    @(posedge clk); #1 out_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {in_ready, busy, out_valid});
    end
    checks++;
    if ({best_score, best_row, best_col} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_best: got %h want 0000", {best_score, best_row, best_col});
    end
  endtask

  task automatic test_basic;
    bit got; res_t obs, e;
    for (int i = 0; i < 16; i++) stim[i] = i;
    drive_scan(1'b0, -1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b want 1 one cycle after last beat", out_valid);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_out(got, obs);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e) begin
      errors++;
      $display("FAIL basic_result: got %h want %h (valid seen %0d)", obs, e, got);
    end
    handshake(1'b0);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_release: out_valid/busy=%b want 00", {out_valid, busy});
    end
  endtask

  task automatic test_tie_negative;
    bit got; res_t obs, e;
    for (int i = 0; i < 16; i++) stim[i] = -2048;
    stim[6] = -5;
    stim[8] = -5;
    drive_scan(1'b0, -1);
    wait_out(got, obs);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e || e !== 16'hFFB6) begin
      errors++;
      $display("FAIL tie_first_wins: got %h want %h", obs, 16'hFFB6);
    end
    handshake(1'b0);
    for (int i = 0; i < 16; i++) stim[i] = -2048;
    drive_scan(1'b0, -1);
    wait_out(got, obs);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e || e !== 16'h8000) begin
      errors++;
      $display("FAIL all_min: got %h want %h", obs, 16'h8000);
    end
    handshake(1'b0);
  endtask

  task automatic test_bubbles;
    bit got; res_t obs, e;
    for (int i = 0; i < 16; i++) stim[i] = i * 3;
    stim[11] = 700;
    drive_scan(1'b1, -1);
    wait_out(got, obs);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e || e !== {12'd700, 2'd2, 2'd3}) begin
      errors++;
      $display("FAIL bubbles_result: got %h want %h", obs, {12'd700, 2'd2, 2'd3});
    end
    handshake(1'b0);
  endtask

  task automatic test_backpressure;
    bit got; res_t obs, e;
    for (int i = 0; i < 16; i++) stim[i] = 50 - i;
    stim[5] = 321;
    drive_scan(1'b0, -1);
    wait_out(got, obs);
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (!got || out_valid !== 1'b1 || {best_score, best_row, best_col} !== e) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d valid=%b got %h want %h",
                 k, out_valid, {best_score, best_row, best_col}, e);
      end
      @(negedge clk);
    end
    handshake(1'b0);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL backpressure_release: valid/busy/ready=%b want 000",
               {out_valid, busy, in_ready});
    end
    checks++;
    if ({best_score, best_row, best_col} !== e) begin
      errors++;
      $display("FAIL backpressure_retain: got %h want %h", {best_score, best_row, best_col}, e);
    end
  endtask

  task automatic test_start_ignored;
    bit got; res_t obs, e;
    for (int i = 0; i < 16; i++) stim[i] = 10 * i - 40;
    stim[3] = 999;
    drive_scan(1'b0, 8);
    wait_out(got, obs);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e) begin
      errors++;
      $display("FAIL start_in_scan: got %h want %h", obs, e);
    end
    handshake(1'b1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b000) begin
        errors++;
        $display("FAIL start_in_done: busy/ready/valid=%b want 000", {busy, in_ready, out_valid});
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    bit got; res_t obs, e;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL scan_ready: ready/busy=%b want 11", {in_ready, busy});
    end
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_score = 12'(1000 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b000 || {best_score, best_row, best_col} !== 16'h0) begin
      errors++;
      $display("FAIL midscan_reset: flags=%b best=%h want 000 0000",
               {in_ready, busy, out_valid}, {best_score, best_row, best_col});
    end
    for (int i = 0; i < 16; i++) stim[i] = (i * 37) % 23 - 11;
    drive_scan(1'b0, -1);
    wait_out(got, obs);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e) begin
      errors++;
      $display("FAIL after_reset_scan: got %h want %h", obs, e);
    end
    handshake(1'b0);
  endtask

  task automatic test_sign_boundary;
    bit got; res_t obs, e;
    for (int i = 0; i < 16; i++) stim[i] = -1;
    stim[1] = 2047;
    drive_scan(1'b0, -1);
    wait_out(got, obs);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e || e !== {12'h7FF, 2'd0, 2'd1}) begin
      errors++;
      $display("FAIL sign_boundary: got %h want %h", obs, {12'h7FF, 2'd0, 2'd1});
    end
    handshake(1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_tie_negative;
    test_bubbles;
    test_backpressure;
    test_start_ignored;
    test_reset_mid_scan;
    test_sign_boundary;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
